// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time to a
// variable-latency instruction memory, holds one output instruction plus one
// buffered response under IF/ID stall, and flushes on branch/jump redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstructionOut,
  output logic [31:0] PCAddResultOut,
  output logic        fetch_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pcadd_q, pcadd_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
  logic [XLEN-1:0]   buf_pcadd_q, buf_pcadd_d;

  logic              req_c;
  logic [XLEN-1:0]   addr_c;
  logic [XLEN-1:0]   pc_plus4;
  logic              consumed;
  logic              slot_free;
  logic              unused_pc_lsbs;

  // Word alignment is enforced by dropping the target's low two bits.
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign pc_plus4  = pc_q + XLEN'(4);
  assign consumed  = valid_q & ~stall;
  assign slot_free = ~valid_q | consumed;

  // Next-state, datapath and request strobe; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pcadd_d     = pcadd_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pcadd_d = buf_pcadd_q;
    req_c       = 1'b0;
    addr_c      = pc_q;

    if (redirect) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      valid_d     = 1'b0;
      buf_instr_d = '0;
      buf_pcadd_d = '0;
      // A request still in flight must have its response swallowed.
      if ((state_q == ST_WAIT || state_q == ST_DISCARD) && !imem_rvalid) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (consumed) valid_d = 1'b0;
          req_c   = 1'b1;
          addr_c  = pc_q;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid && slot_free) begin
            instr_d = imem_rdata;
            pcadd_d = pc_plus4;
            valid_d = 1'b1;
            req_c   = 1'b1;
            addr_c  = pc_plus4;
            pc_d    = pc_plus4;
          end else if (imem_rvalid) begin
            buf_instr_d = imem_rdata;
            buf_pcadd_d = pc_plus4;
            pc_d        = pc_plus4;
            state_d     = ST_HOLD;
          end else if (consumed) begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (consumed) begin
            instr_d = buf_instr_q;
            pcadd_d = buf_pcadd_q;
            valid_d = 1'b1;
            req_c   = 1'b1;
            addr_c  = pc_q;
            state_d = ST_WAIT;
          end
        end
        ST_DISCARD: begin
          if (consumed) valid_d = 1'b0;
          if (imem_rvalid) begin
            req_c   = 1'b1;
            addr_c  = pc_q;
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // No request is offered while reset holds the FSM in IDLE.
  assign imem_req  = req_c & ~reset;
  assign imem_addr = addr_c;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pcadd_q     <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pcadd_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcadd_q     <= pcadd_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pcadd_q <= buf_pcadd_d;
    end
  end

  assign InstructionOut = instr_q;
  assign PCAddResultOut = pcadd_q;
  assign fetch_valid    = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: variable-latency memory model plus an
// in-order scoreboard of expected IF/ID outputs.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcadd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstructionOut, PCAddResultOut;
  logic        fetch_valid;

  logic        imem_req1;
  logic [31:0] imem_addr1;
  logic        imem_rvalid1;
  logic [31:0] imem_rdata1;
  logic [31:0] instr1, pcadd1;
  logic        fv1;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstructionOut(InstructionOut), .PCAddResultOut(PCAddResultOut),
    .fetch_valid(fetch_valid)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_rvalid(imem_rvalid1), .imem_rdata(imem_rdata1),
    .InstructionOut(instr1), .PCAddResultOut(pcadd1), .fetch_valid(fv1)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  int          lat;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] exp_addr;
  bit          stale;
  logic        last_req;
  logic [31:0] last_addr;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_addr = 32'h0;
    mem_pend = 1'b0;
    mem_cnt  = 0;
    stale    = 1'b0;
  endtask

  // One clock: drive memory, check consumption/requests, advance the model.
  task automatic cycle();
    exp_t        e;
    logic        rsp, req;
    logic [31:0] raddr;
    imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? (mem_addr ^ 32'hA5A5_0000) : 32'h0;
    #1;
    rsp = imem_rvalid;
    req = imem_req;
    raddr = exp_addr;
    last_req = req;
    last_addr = imem_addr;
    if (fetch_valid && !stall) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", 32'(fetch_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("instr", InstructionOut, e.instr);
        check_val("pcadd", PCAddResultOut, e.pcadd);
      end
    end
    if (req) begin
      check_val("req_addr", imem_addr, exp_addr);
      if (mem_pend && !rsp) check_val("one_outstanding", 32'(req), 32'd0);
    end
    if (redirect) check_val("req_on_redirect", 32'(req), 32'd0);
    if (rsp) begin
      if (stale) stale = 1'b0;
      else if (!redirect) sb.push_back('{instr: mem_addr ^ 32'hA5A5_0000, pcadd: mem_addr + 32'd4});
    end
    if (redirect) begin
      sb.delete();
      exp_addr = {redirect_pc[31:2], 2'b00};
      stale = mem_pend && !rsp;
    end else if (req) begin
      exp_addr = exp_addr + 32'd4;
    end
    if (rsp) mem_pend = 1'b0;
    if (req) begin
      mem_pend = 1'b1;
      mem_addr = raddr;
      mem_cnt  = lat - 1;
    end else if (mem_pend) begin
      mem_cnt--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit got_req;
    logic [31:0] p0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    imem_rvalid1 = 1'b0; imem_rdata1 = 32'h0;
    lat = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", 32'(fetch_valid), 32'd0);
    check_val("rst_instr", InstructionOut, 32'd0);
    check_val("rst_pcadd", PCAddResultOut, 32'd0);
    reset = 1'b0;

    // Back-to-back fetch with a 1-cycle memory.
    cycle();
    check_val("first_req", 32'(last_req), 32'd1);
    check_val("fv_edge1", 32'(fetch_valid), 32'd0);
    cycle();
    check_val("fv_edge2", 32'(fetch_valid), 32'd1);
    check_val("pcadd_first", PCAddResultOut, 32'd4);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_val("throughput_req", 32'(last_req), 32'd1);
    end

    // Stall while a response lands: buffer it, then drain on release.
    p0 = PCAddResultOut;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("hold_no_req", 32'(last_req), 32'd0);
      check_val("hold_valid", 32'(fetch_valid), 32'd1);
      check_val("hold_pcadd", PCAddResultOut, p0);
    end
    stall = 1'b0;
    cycle();
    check_val("release_req", 32'(last_req), 32'd1);
    check_val("release_pcadd", PCAddResultOut, p0 + 32'd4);
    for (int i = 0; i < 3; i++) cycle();

    // Redirect while a 3-cycle request is outstanding.
    lat = 3;
    n = 0;
    while (!(mem_pend && mem_cnt == 2) && n < 10) begin cycle(); n++; end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    check_val("redir_valid", 32'(fetch_valid), 32'd0);
    n = 0; got_req = 1'b0;
    while (!fetch_valid && n < 20) begin
      cycle();
      if (last_req && !got_req) begin
        got_req = 1'b1;
        check_val("redir_addr", last_addr, 32'h0000_0100);
      end
      n++;
    end
    check_val("redir_timeout", 32'(fetch_valid), 32'd1);
    check_val("redir_pcadd", PCAddResultOut, 32'h0000_0104);
    for (int i = 0; i < 4; i++) cycle();

    // Redirect coinciding with a response.
    n = 0;
    while (!(mem_pend && mem_cnt == 0) && n < 10) begin cycle(); n++; end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    redirect = 1'b0;
    check_val("redir2_valid", 32'(fetch_valid), 32'd0);
    cycle();
    check_val("redir2_req", 32'(last_req), 32'd1);
    check_val("redir2_addr", last_addr, 32'h0000_0200);
    n = 0;
    while (!fetch_valid && n < 20) begin cycle(); n++; end
    check_val("redir2_pcadd", PCAddResultOut, 32'h0000_0204);

    // Reset asserted while holding a buffered response.
    lat = 1;
    n = 0;
    while (!(fetch_valid && mem_pend && mem_cnt == 0) && n < 20) begin cycle(); n++; end
    stall = 1'b1;
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check_val("midrst_valid", 32'(fetch_valid), 32'd0);
    check_val("midrst_instr", InstructionOut, 32'd0);
    check_val("midrst_pcadd", PCAddResultOut, 32'd0);
    imem_rvalid = 1'b0;
    stall = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    check_val("postrst_req", 32'(last_req), 32'd1);
    check_val("postrst_addr", last_addr, 32'h0);
    for (int i = 0; i < 4; i++) cycle();

    // PC wrap from the top of the address space.
    reset = 1'b1;
    imem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("wrap_req0", 32'(imem_req1), 32'd1);
    check_val("wrap_addr0", imem_addr1, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    imem_rvalid1 = 1'b1; imem_rdata1 = 32'hDEAD_BEEF;
    #1;
    check_val("wrap_req1", 32'(imem_req1), 32'd1);
    check_val("wrap_addr1", imem_addr1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    imem_rvalid1 = 1'b0;
    #1;
    check_val("wrap_valid", 32'(fv1), 32'd1);
    check_val("wrap_pcadd", pcadd1, 32'h0);
    check_val("wrap_instr", instr1, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to an instruction memory with variable latency over a req/rvalid handshake. Exactly one request is outstanding at a time.
- Holds at most one output instruction plus one buffered response while the hazard unit stalls IF/ID.
- Redirects on branch/jump and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  1 = IF/ID will not write this cycle (hazard unit's inverted write)
- redirect  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  target address; bits [1:0] forced to 0
- imem_req  out  1  one-cycle request strobe (combinational)
- imem_addr  out  32  request address, valid when imem_req=1
- imem_rvalid  in  1  response valid; exactly one per request, ≥1 cycle after req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- InstructionOut  out  32  instruction presented to IF/ID
- PCAddResultOut  out  32  fetch address of InstructionOut + 4
- fetch_valid  out  1  InstructionOut/PCAddResultOut are valid

Behaviour:
- Reset (async, immediate): PC=RESET_PC; state=IDLE; InstructionOut=0; PCAddResultOut=0; fetch_valid=0; buffer empty.
- PC holds the address of the outstanding or next request. All state and output registers update on posedge clk.
- consumed = fetch_valid & ~stall at a clock edge. slot_free = ~fetch_valid | consumed.
- States:
  - IDLE: imem_req=1, imem_addr=PC → WAIT.
  - WAIT, imem_rvalid & slot_free: load output with imem_rdata and PC+4; fetch_valid<=1; imem_req=1 same cycle, imem_addr=PC+4; PC<=PC+4; stay in WAIT.
  - WAIT, imem_rvalid & ~slot_free: capture imem_rdata and PC+4 into buffer; PC<=PC+4; no request → HOLD.
  - WAIT, no rvalid: hold. If consumed, fetch_valid<=0.
  - HOLD, consumed: move buffer to output (fetch_valid stays 1); imem_req=1, imem_addr=PC → WAIT.
  - HOLD, not consumed: hold everything.
  - DISCARD: a stale request is in flight. On imem_rvalid, drop the data; imem_req=1, imem_addr=PC → WAIT.
- Redirect has highest priority, in any state except during reset:
  - PC<={redirect_pc[31:2],2'b00}; fetch_valid<=0; buffer cleared; imem_req=0 that cycle.
  - Next state = DISCARD if state was WAIT or DISCARD and imem_rvalid=0 that cycle; otherwise IDLE (any same-cycle response is dropped).
- Throughput: 1 instruction/cycle with 1-cycle memory and no stalls. Latency from req to fetch_valid = memory latency + 1 edge.
- Stall with fetch_valid=0 has no effect on fetching.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- No instruction is ever duplicated or dropped except by redirect.

Test Plan:
- Reset with RESET_PC=0, 1-cycle memory returning addr^32'hA5A5_0000 → requests at 0,4,8,… on consecutive cycles; fetch_valid=1 from the 2nd edge; PCAddResultOut sequence 4,8,12.
- stall=1 for 3 cycles while fetch_valid=1 and a response arrives → response buffered, HOLD, imem_req=0; on release, outputs show the next instruction (PCAddResultOut advances by exactly 4) and a request issues for the following address.
- redirect to 32'h0000_0103 while a 3-cycle-latency request is outstanding → next fetch_valid=0; stale response dropped; next imem_addr=32'h0000_0100; first valid PCAddResultOut=32'h0000_0104.
- redirect in the same cycle as imem_rvalid → response dropped; IDLE; request to the target on the next cycle.
- Assert reset mid-HOLD → outputs and fetch_valid clear immediately; after deassert, first request at RESET_PC.
- RESET_PC=32'hFFFF_FFFC → first PCAddResultOut=0; second request address=0.
